// File: rtl/wishbone_write_checker_pkg.sv
// wishbone_write_checker_pkg: state/error encodings and sel-to-byte-mask expansion for the write checker.
package wishbone_write_checker_pkg;
  localparam int MAX_W = 256;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE, ST_FAIL} wb_chk_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_SEL_MISMATCH, ERR_DATA_MISMATCH, ERR_TIMEOUT} wb_chk_err_t;
  function automatic logic [MAX_W-1:0] sel_to_mask(input logic [MAX_W-1:0] sel, input int unsigned byte_size);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = sel[i / byte_size];
    return m;
  endfunction
endpackage

// File: rtl/wishbone_write_checker_if.sv
// wishbone_write_checker_if: Wishbone B4 write-side signals with driver, responder and passive snoop views.
interface wishbone_write_checker_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
);
  logic cyc, stb, we, ack;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE/BYTE_SIZE-1:0] sel;
  logic [DATA_SIZE-1:0] dat;
  modport master(output cyc, stb, we, addr, sel, dat, input ack);
  modport slave(input cyc, stb, we, addr, sel, dat, output ack);
  modport monitor(input cyc, stb, we, ack, addr, sel, dat);
endinterface

// File: rtl/wishbone_write_checker.sv
// wishbone_write_checker: snoops acked writes in an address window, checks sel/data, counts passes, flags first failure or timeout.
module wishbone_write_checker
  import wishbone_write_checker_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int ADDR_SIZE = 32,
  parameter int NUM_CHECKS = 1,
  parameter logic [ADDR_SIZE-1:0] ADDR_MATCH = 'h8000_0000,
  parameter logic [ADDR_SIZE-1:0] ADDR_MASK = 'hFFFF_FC00,
  parameter logic [DATA_SIZE/BYTE_SIZE-1:0] EXP_SEL = '1,
  parameter logic [DATA_SIZE-1:0] EXP_DATA = '0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic clock,
  input logic reset_n,
  input logic enable,
  input logic clear,
  wishbone_write_checker_if.monitor wb,
  output logic [$clog2(NUM_CHECKS+1)-1:0] pass_count,
  output logic done,
  output logic error,
  output wb_chk_err_t error_code,
  output logic [ADDR_SIZE-1:0] err_addr,
  output logic [DATA_SIZE-1:0] err_data
);
  localparam int PW = $clog2(NUM_CHECKS+1);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam logic [DATA_SIZE-1:0] LANE_MASK = DATA_SIZE'(sel_to_mask(MAX_W'(EXP_SEL), BYTE_SIZE));
  wb_chk_state_t state, state_nxt;
  logic [TW-1:0] tcnt;
  logic hit, armed, sel_bad, data_bad, bad, last, timed_out, to_fail;
  assign hit = wb.cyc & wb.stb & wb.we & wb.ack & ((wb.addr & ADDR_MASK) == ADDR_MATCH);
  assign armed = state == ST_ARMED && enable;
  assign sel_bad = wb.sel != EXP_SEL;
  assign data_bad = |((wb.dat ^ EXP_DATA) & LANE_MASK);
  assign bad = sel_bad | data_bad;
  assign last = pass_count + 1'b1 == PW'(NUM_CHECKS);
  assign timed_out = TIMEOUT_CYCLES != 0 && tcnt == TW'(TIMEOUT_CYCLES);
  // a hit on the timeout cycle takes precedence over the timeout
  assign to_fail = armed && !hit && timed_out;
  assign done = state == ST_DONE;
  assign error = state == ST_FAIL;
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) state_nxt = enable ? ST_ARMED : ST_IDLE;
    else if (state == ST_ARMED)
      state_nxt = !enable ? ST_IDLE : hit && bad ? ST_FAIL : hit && last ? ST_DONE : to_fail ? ST_FAIL : ST_ARMED;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      tcnt <= '0;
      pass_count <= '0;
      error_code <= ERR_NONE;
      err_addr <= '0;
      err_data <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      tcnt <= '0;
      pass_count <= '0;
      error_code <= ERR_NONE;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      state <= state_nxt;
      tcnt <= armed && !hit ? tcnt + 1'b1 : '0;
      if (armed && hit && !bad) pass_count <= pass_count + 1'b1;
      if (armed && hit && bad) begin
        error_code <= sel_bad ? ERR_SEL_MISMATCH : ERR_DATA_MISMATCH;
        err_addr <= wb.addr;
        err_data <= wb.dat;
      end else if (to_fail) error_code <= ERR_TIMEOUT;
    end
  end
endmodule
